// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN geometry constants and collector state encoding
package cnn_pkg;

    localparam int OUT_DIM    = 14;
    localparam int DW         = 9;
    localparam int AW         = 8;
    localparam int FRAME_SIZE = OUT_DIM * OUT_DIM;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_DONE = 1'b1
    } state_t;

endpackage

// File: rtl/fmap_ram.sv
// rtl/fmap_ram.sv - simple dual-port feature-map RAM with registered read
module fmap_ram #(
    parameter int DEPTH = cnn_pkg::FRAME_SIZE,
    parameter int DW    = cnn_pkg::DW,
    parameter int AW    = cnn_pkg::AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_we,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rd_data;

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/pool_collector.sv
// rtl/pool_collector.sv - captures one pooled frame, tracks position, max and overrun
module pool_collector #(
    parameter int OUT_DIM = cnn_pkg::OUT_DIM,
    parameter int DW      = cnn_pkg::DW,
    parameter int AW      = cnn_pkg::AW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [DW-1:0] pool_in,
    input  logic                 valid,
    input  logic                 clear,
    input  logic        [AW-1:0] rd_addr,
    output logic signed [DW-1:0] rd_data,
    output logic        [AW-1:0] count,
    output logic        [AW-1:0] row,
    output logic        [AW-1:0] col,
    output logic                 frame_done,
    output logic                 overflow,
    output logic signed [DW-1:0] max_val,
    output logic        [AW-1:0] max_idx
);

    localparam int            FRAME    = OUT_DIM * OUT_DIM;
    localparam logic [AW-1:0] LAST_IDX = AW'(FRAME - 1);
    localparam logic [AW-1:0] LAST_COL = AW'(OUT_DIM - 1);

    cnn_pkg::state_t r_state;
    cnn_pkg::state_t w_state_next;

    logic        [AW-1:0] r_count;
    logic        [AW-1:0] r_row;
    logic        [AW-1:0] r_col;
    logic                 r_overflow;
    logic signed [DW-1:0] r_max_val;
    logic        [AW-1:0] r_max_idx;

    logic                 w_in_done;
    logic                 w_restart;
    logic                 w_accept;
    logic        [AW-1:0] w_wr_addr;
    logic        [AW-1:0] w_row_base;
    logic        [AW-1:0] w_col_base;
    logic                 w_last;
    logic                 w_new_max;
    logic        [DW-1:0] w_rd_data;

    // A clear in DONE restarts the frame so a same-cycle element lands at index 0.
    assign w_in_done  = (r_state == cnn_pkg::ST_DONE);
    assign w_restart  = w_in_done && clear;
    assign w_accept   = valid && (!w_in_done || clear);
    assign w_wr_addr  = w_restart ? '0 : r_count;
    assign w_row_base = w_restart ? '0 : r_row;
    assign w_col_base = w_restart ? '0 : r_col;
    assign w_last     = (w_wr_addr == LAST_IDX);
    assign w_new_max  = (w_wr_addr == '0) || (pool_in > r_max_val);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            cnn_pkg::ST_FILL: begin
                if (w_accept && w_last) begin
                    w_state_next = cnn_pkg::ST_DONE;
                end
            end
            cnn_pkg::ST_DONE: begin
                if (clear) begin
                    w_state_next = (w_accept && w_last) ? cnn_pkg::ST_DONE : cnn_pkg::ST_FILL;
                end
            end
            default: w_state_next = cnn_pkg::ST_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= cnn_pkg::ST_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_overflow <= 1'b0;
            r_max_val  <= '0;
            r_max_idx  <= '0;
        end else begin
            if (w_restart) begin
                r_count    <= '0;
                r_row      <= '0;
                r_col      <= '0;
                r_overflow <= 1'b0;
            end else if (w_in_done && valid) begin
                r_overflow <= 1'b1;
            end

            if (w_accept) begin
                r_count <= w_wr_addr + 1'b1;
                if (w_last) begin
                    r_row <= '0;
                    r_col <= '0;
                end else if (w_col_base == LAST_COL) begin
                    r_row <= w_row_base + 1'b1;
                    r_col <= '0;
                end else begin
                    r_row <= w_row_base;
                    r_col <= w_col_base + 1'b1;
                end
                if (w_new_max) begin
                    r_max_val <= pool_in;
                    r_max_idx <= w_wr_addr;
                end
            end
        end
    end

    fmap_ram #(
        .DEPTH (FRAME),
        .DW    (DW),
        .AW    (AW)
    ) u_fmap_ram (
        .clk       (clk),
        .reset     (reset),
        .i_we      (w_accept && !reset),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (pool_in),
        .i_rd_addr (rd_addr),
        .o_rd_data (w_rd_data)
    );

    assign rd_data    = w_rd_data;
    assign count      = r_count;
    assign row        = r_row;
    assign col        = r_col;
    assign frame_done = w_in_done;
    assign overflow   = r_overflow;
    assign max_val    = r_max_val;
    assign max_idx    = r_max_idx;

endmodule
